encoder_rate_sched: RTL

//  Time-base and sequencing controller for N_CH motor-encoder channels.

---
 rtl/encoder_rate_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/encoder_rate_sched.sv
// encoder_rate_sched: shared measurement window and result sequencer for
// N_CH motor-encoder channels.
//
// Each channel's pulse strobes are counted over a WIN_CYC-cycle window. At the
// window's last cycle all counts are snapshotted. Each snapshot then passes, one
// channel at a time, through a single scale unit: (cnt*SCALE_MUL)>>SCALE_SHIFT.
// Results leave on one valid/ready stream tagged with the channel index.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   en         measurement enable; when low, the timer and counters are held at 0
//   pulse      per-channel one-cycle edge strobes, already synchronised
//   rpm_data   scaled result, saturated to 32 bits
//   rpm_ch     channel index of rpm_data
//   rpm_valid  result valid; held until rpm_ready
//   rpm_ready  downstream accept
//   win_tick   one-cycle strobe on the window's last cycle
//   busy       high while a result sweep is in progress
//   overrun    sticky; set when a window snapshot was dropped
module encoder_rate_sched #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned WIN_CYC     = 100_000_000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SCALE_MUL   = 6,
  parameter int unsigned SCALE_SHIFT = 4,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] pulse,
  output logic [31:0]     rpm_data,
  output logic [CH_W-1:0] rpm_ch,
  output logic            rpm_valid,
  input  logic            rpm_ready,
  output logic            win_tick,
  output logic            busy,
  output logic            overrun
);

  localparam int unsigned TMR_W  = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam int unsigned PROD_W = CNT_W + 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_CYC - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCALE   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  cnt  [N_CH];
  logic [CNT_W-1:0]  snap [N_CH];
  logic [CH_W-1:0]   idx;
  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] shifted;
  logic [31:0]       scaled;

  // Last cycle of the window; en gates it so a disabled window never ends.
  assign win_tick = en && (timer == TMR_LAST);

  // Window timer: free-runs 0..WIN_CYC-1 while enabled, otherwise held at 0.
  always_ff @(posedge clk) begin
    if (rst || !en || win_tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Pulse counters. A pulse on the tick cycle seeds the next window's count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N_CH); i++) begin
      if (rst || !en) begin
        cnt[i] <= '0;
      end else if (win_tick) begin
        cnt[i] <= CNT_W'(pulse[i]);
      end else if (pulse[i] && (cnt[i] != '1)) begin
        cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Shared scale unit on the currently selected snapshot.
  always_comb begin
    product = PROD_W'(snap[idx]) * PROD_W'(SCALE_MUL);
    shifted = product >> SCALE_SHIFT;
    scaled  = (shifted > PROD_W'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : 32'(shifted);
  end

  // Sequencer: snapshot on an accepted tick, then scale/present each channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      rpm_data  <= '0;
      rpm_ch    <= '0;
      rpm_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) begin
        snap[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (win_tick) begin
            for (int i = 0; i < int'(N_CH); i++) begin
              snap[i] <= cnt[i];
            end
            idx   <= '0;
            busy  <= 1'b1;
            state <= SCALE;
          end
        end
        SCALE: begin
          rpm_data  <= scaled;
          rpm_ch    <= idx;
          rpm_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (rpm_valid && rpm_ready) begin
            rpm_valid <= 1'b0;
            if (idx == CH_LAST) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx   <= idx + CH_W'(1);
              state <= SCALE;
            end
          end
        end
        default: begin
          rpm_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase

      // A tick arriving mid-sweep cannot be snapshotted; flag it.
      if (win_tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
